// File: rtl/fp8_issue_ctrl_pkg.sv
// Shared definitions for the FP8 issue controller: op codes, unit flag bit
// positions, FSM state type and the queued response record.
package fp8_issue_ctrl_pkg;

  localparam logic [1:0] OP_ADD      = 2'b00;
  localparam logic [1:0] OP_SUB      = 2'b01;
  localparam logic [1:0] OP_MUL      = 2'b10;
  localparam logic [1:0] OP_RESERVED = 2'b11;

  // Bit positions inside the 4-bit {zero,overflow,underflow,inexact} flag field.
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_ZERO      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } issue_state_t;

  typedef struct packed {
    logic [7:0] result;
    logic [3:0] flags;
    logic [3:0] tag;
    logic       timeout;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/fp8_rsp_fifo.sv
// Response FIFO: power-of-two depth, first-word-fall-through head, occupancy
// count; a push into a full FIFO is only taken when a pop frees a slot that cycle.
module fp8_rsp_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; only pointers and count
  // define validity, and the consumer masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: every clocked assignment is non-blocking so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fp8_issue_ctrl.sv
// Single-outstanding issue controller between a command stream and an FP8
// arithmetic unit, with timeout detection and an in-order response FIFO.
module fp8_issue_ctrl
  import fp8_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RSP_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_tag,
  output logic       unit_start,
  output logic [7:0] unit_a,
  output logic [7:0] unit_b,
  output logic [1:0] unit_op,
  input  logic       unit_done,
  input  logic [7:0] unit_result,
  input  logic [3:0] unit_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_flags,
  output logic [3:0] rsp_tag,
  output logic       rsp_timeout,
  output logic [7:0] err_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FCW   = $clog2(RSP_DEPTH) + 1;

  issue_state_t     state_q, state_d;
  logic [7:0]       a_q, b_q;
  logic [1:0]       op_q;
  logic [3:0]       tag_q;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [7:0]       err_q;

  logic             accept;
  logic             push;
  logic             timeout_evt;
  logic             spurious_done;
  rsp_t             push_rsp;
  rsp_t             head_rsp;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;

  // Accepting only from IDLE with a free slot reserves room for the response
  // of the op being issued, so a push can never find the FIFO full.
  assign cmd_ready     = reset_n & (state_q == ST_IDLE) & (fifo_count < FCW'(RSP_DEPTH));
  assign accept        = cmd_valid & cmd_ready;
  assign spurious_done = unit_done & (state_q != ST_WAIT);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    unit_start  = 1'b0;
    push        = 1'b0;
    timeout_evt = 1'b0;
    push_rsp    = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        unit_start = 1'b1;
        wait_d     = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the last allowed cycle beats the timeout.
        if (unit_done) begin
          push     = 1'b1;
          push_rsp = '{result: unit_result, flags: unit_flags, tag: tag_q, timeout: 1'b0};
          state_d  = ST_IDLE;
        end else if (wait_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          push        = 1'b1;
          timeout_evt = 1'b1;
          push_rsp    = '{result: 8'h00, flags: 4'h0, tag: tag_q, timeout: 1'b1};
          state_d     = ST_IDLE;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      tag_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (accept) begin
        a_q   <= cmd_a;
        b_q   <= cmd_b;
        op_q  <= cmd_op;
        tag_q <= cmd_tag;
      end
      if ((timeout_evt | spurious_done) && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  fp8_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_rsp),
    .pop       (rsp_ready),
    .head      (head_rsp),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign unit_a    = a_q;
  assign unit_b    = b_q;
  assign unit_op   = op_q;
  assign err_count = err_q;

  // Head fields read as zero while nothing is queued.
  assign rsp_valid   = ~fifo_empty;
  assign rsp_result  = rsp_valid ? head_rsp.result  : 8'h00;
  assign rsp_flags   = rsp_valid ? head_rsp.flags   : 4'h0;
  assign rsp_tag     = rsp_valid ? head_rsp.tag     : 4'h0;
  assign rsp_timeout = rsp_valid ? head_rsp.timeout : 1'b0;

endmodule

// File: tb/tb_fp8_issue_ctrl.sv
// Directed bench for fp8_issue_ctrl: a transaction-level model (outstanding op
// record plus expected-response queue) checked every cycle, and pinned literals.
module tb_fp8_issue_ctrl;
  import fp8_issue_ctrl_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_tag = '0;
  logic       unit_start;
  logic [7:0] unit_a, unit_b;
  logic [1:0] unit_op;
  logic       unit_done = 1'b0;
  logic [7:0] unit_result = '0;
  logic [3:0] unit_flags = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags, rsp_tag;
  logic       rsp_timeout;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  fp8_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b), .unit_op(unit_op),
    .unit_done(unit_done), .unit_result(unit_result), .unit_flags(unit_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .rsp_timeout(rsp_timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] result;
    logic [3:0] flags;
    logic [3:0] tag;
    logic       timeout;
  } exp_t;

  exp_t       m_q[$];
  bit         m_busy = 1'b0;
  int         m_age  = 0;      // 0 = start cycle, k = k-th cycle waiting for done
  logic [7:0] m_a = '0, m_b = '0;
  logic [1:0] m_op = '0;
  logic [3:0] m_tag = '0;
  int         m_err = 0;

  function automatic bit model_ready();
    return !m_busy && (m_q.size() < DEPTH);
  endfunction

  task automatic model_bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step();
    exp_t e;
    bit   rdy;
    rdy = model_ready();
    if (rsp_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (!m_busy) begin
      if (unit_done) model_bump_err();
      if (cmd_valid && rdy) begin
        m_busy = 1'b1; m_age = 0;
        m_a = cmd_a; m_b = cmd_b; m_op = cmd_op; m_tag = cmd_tag;
      end
    end else if (m_age == 0) begin
      if (unit_done) model_bump_err();
      m_age = 1;
    end else if (unit_done) begin
      e.result = unit_result; e.flags = unit_flags; e.tag = m_tag; e.timeout = 1'b0;
      m_q.push_back(e);
      m_busy = 1'b0;
    end else if (m_age == TIMEOUT) begin
      e.result = 8'h00; e.flags = 4'h0; e.tag = m_tag; e.timeout = 1'b1;
      m_q.push_back(e);
      model_bump_err();
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_q.delete();
      m_busy = 1'b0; m_age = 0; m_err = 0;
      m_a = '0; m_b = '0; m_op = '0; m_tag = '0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    exp_t h;
    @(negedge clk);
    if (reset_n) begin
      check("cmd_ready", cmd_ready, model_ready());
      check("unit_start", unit_start, m_busy && (m_age == 0));
      if (m_busy) begin
        check("unit_a", unit_a, m_a);
        check("unit_b", unit_b, m_b);
        check("unit_op", unit_op, m_op);
      end
      check("rsp_valid", rsp_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        h = m_q[0];
        check("rsp_result", rsp_result, h.result);
        check("rsp_flags", rsp_flags, h.flags);
        check("rsp_tag", rsp_tag, h.tag);
        check("rsp_timeout", rsp_timeout, h.timeout);
      end
      check("err_count", err_count, m_err[7:0]);
    end
  end

  initial forever begin
    @(negedge clk);
    if (unit_start) start_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a command, wait for acceptance, then play the arithmetic unit:
  // done is raised in the delay-th wait cycle (delay < 0: never).
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic [3:0] tag, input int delay, input logic [7:0] res,
                       input logic [3:0] flg, input bit rdy_at_done);
    int n;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 200);
    check("cmd_accept_bound", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("unit_start_after_accept", unit_start, 1'b1);
    step();
    if (delay > 0) begin
      repeat (delay - 1) step();
      unit_result = res; unit_flags = flg; unit_done = 1'b1;
      if (rdy_at_done) rsp_ready = 1'b1;
      step();
      unit_done = 1'b0; unit_result = '0; unit_flags = '0;
      if (rdy_at_done) rsp_ready = 1'b0;
    end
  endtask

  // Returns on the negedge where rsp_valid is first seen; n = negedges waited.
  task automatic wait_rsp(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
    check("rsp_valid_bound", rsp_valid, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    repeat (2) begin
      @(negedge clk);
      check("reset_cmd_ready", cmd_ready, 1'b0);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_unit_start", unit_start, 1'b0);
      check("reset_unit_a", unit_a, 8'h00);
      check("reset_unit_op", unit_op, 2'b00);
      check("reset_rsp_result", rsp_result, 8'h00);
      check("reset_err_count", err_count, 8'h00);
    end
    step();
    reset_n = 1'b1;
    step();

    // add 1.0 + 1.0, unit answers in the second wait cycle
    do_op(8'h38, 8'h38, OP_ADD, 4'd1, 2, 8'h40, 4'h0, 1'b0);
    wait_rsp(n);
    check("add_rsp_latency", n, 1);
    check("add_result", rsp_result, 8'h40);
    check("add_tag", rsp_tag, 4'd1);
    check("add_timeout", rsp_timeout, 1'b0);
    step();

    // mul 2.0 * 2.0, one start pulse only
    start_cnt = 0;
    do_op(8'h40, 8'h40, OP_MUL, 4'd2, 1, 8'h48, 4'(1 << FLAG_INEXACT), 1'b0);
    wait_rsp(n);
    check("mul_result", rsp_result, 8'h48);
    check("mul_flags", rsp_flags, 4'b0001);
    check("mul_start_pulses", start_cnt, 1);
    step();

    // unit never answers: timeout after 16 wait cycles, then a late done
    do_op(8'h11, 8'h22, OP_SUB, 4'd3, -1, 8'h00, 4'h0, 1'b0);
    wait_rsp(n);
    check("timeout_latency", n, 17);
    check("timeout_flag", rsp_timeout, 1'b1);
    check("timeout_result", rsp_result, 8'h00);
    check("timeout_tag", rsp_tag, 4'd3);
    check("timeout_err", err_count, 8'd1);
    step();
    unit_done = 1'b1;
    step();
    unit_done = 1'b0;
    step();
    @(negedge clk);
    check("late_done_err", err_count, 8'd2);
    check("late_done_no_rsp", rsp_valid, 1'b0);
    step();

    // reserved op goes to the unit like any other
    do_op(8'h01, 8'h02, OP_RESERVED, 4'd7, 1, 8'h7F, 4'(1 << FLAG_OVERFLOW), 1'b0);
    wait_rsp(n);
    check("rsvd_result", rsp_result, 8'h7F);
    check("rsvd_flags", rsp_flags, 4'b0100);
    step();

    // done in the very cycle the timeout would fire
    do_op(8'h05, 8'h06, OP_ADD, 4'd8, TIMEOUT, 8'h55, 4'(1 << FLAG_ZERO), 1'b0);
    wait_rsp(n);
    check("race_timeout", rsp_timeout, 1'b0);
    check("race_result", rsp_result, 8'h55);
    check("race_err", err_count, 8'd2);
    step();

    // back-pressure: four queued responses block the fifth command
    rsp_ready = 1'b0;
    for (int t = 0; t < 4; t++)
      do_op(8'(8'h20 + t), 8'h30, OP_ADD, 4'(t), 1, 8'(8'h10 + t), 4'h0, 1'b0);
    cmd_a = 8'h24; cmd_b = 8'h30; cmd_op = OP_ADD; cmd_tag = 4'd4; cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_cmd_ready", cmd_ready, 1'b0);
      check("full_rsp_valid", rsp_valid, 1'b1);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("full_head_tag", rsp_tag, 4'd0);
    step();
    rsp_ready = 1'b0;
    do_op(8'h24, 8'h30, OP_ADD, 4'd4, 1, 8'h14, 4'h0, 1'b0);
    rsp_ready = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      wait_rsp(n);
      check("order_tag", rsp_tag, 32'(t));
      check("order_result", rsp_result, 32'(8'h10 + t));
      step();
    end

    // push and pop in the same cycle keep exactly one entry
    rsp_ready = 1'b0;
    do_op(8'h61, 8'h62, OP_SUB, 4'd5, 1, 8'hA5, 4'h0, 1'b0);
    do_op(8'h63, 8'h64, OP_SUB, 4'd6, 1, 8'hA6, 4'h0, 1'b1);
    @(negedge clk);
    check("pushpop_valid", rsp_valid, 1'b1);
    check("pushpop_tag", rsp_tag, 4'd6);
    step();
    rsp_ready = 1'b1;
    step();

    // reset while waiting abandons the op
    do_op(8'h70, 8'h71, OP_MUL, 4'd9, -1, 8'h00, 4'h0, 1'b0);
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b0);
    check("midrst_unit_start", unit_start, 1'b0);
    check("midrst_unit_a", unit_a, 8'h00);
    check("midrst_err", err_count, 8'h00);
    step();
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("midrst_no_rsp", rsp_valid, 1'b0);
    end
    step();
    do_op(8'h38, 8'h40, OP_ADD, 4'd10, 1, 8'h3C, 4'h0, 1'b0);
    wait_rsp(n);
    check("post_rst_tag", rsp_tag, 4'd10);
    check("post_rst_result", rsp_result, 8'h3C);
    step();

    // spurious done every idle cycle: counter saturates
    unit_done = 1'b1;
    repeat (260) step();
    unit_done = 1'b0;
    step();
    @(negedge clk);
    check("err_saturated", err_count, 8'hFF);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp8_issue_ctrl.md
FP8_ISSUE_CTRL -- requirements
Module: fp8_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles waited for unit_done after unit_start.
REQ-002 SHALL have parameter RSP_DEPTH, default 4, response FIFO entries (power of two, >=2).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  async active-low reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-008 cmd_a, cmd_b  input  8 each  FP8 operands.
REQ-009 cmd_op  input  2  00 add, 01 sub, 10 mul, 11 reserved.
REQ-010 cmd_tag  input  4  opaque ID returned with the response.
REQ-011 unit_start  output  1  single-cycle start pulse to the arithmetic unit.
REQ-012 unit_a, unit_b  output  8 each; unit_op  output  2  operands/op to the unit.
REQ-013 unit_done  input  1; unit_result  input  8; unit_flags  input  4 {zero,overflow,underflow,inexact}.
REQ-014 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-015 rsp_result  output  8; rsp_flags  output  4; rsp_tag  output  4; rsp_timeout  output  1.
REQ-016 err_count  output  8  saturating count of timeouts plus spurious unit_done pulses.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT; exactly one operation outstanding at any time.
REQ-018 cmd_ready SHALL be 1 only in IDLE with response FIFO count < RSP_DEPTH; a slot is thereby reserved for every issued op.
REQ-019 On accept: latch a, b, op, tag; IDLE->ISSUE.
REQ-020 ISSUE: unit_start=1 for exactly one cycle, then ->WAIT; wait counter cleared.
REQ-021 unit_a/unit_b/unit_op SHALL hold latched values stable from ISSUE until return to IDLE.
REQ-022 WAIT: counter increments each cycle; unit_done=1 -> push {unit_result, unit_flags, tag, timeout=0}, ->IDLE.
REQ-023 WAIT: counter reaching TIMEOUT_CYCLES without unit_done -> push {8'h00, 4'b0000, tag, timeout=1}, err_count+1, ->IDLE.
REQ-024 unit_done in IDLE or ISSUE SHALL be ignored for data and increment err_count (spurious/late done).
REQ-025 unit_done and timeout in same cycle: done wins, no timeout recorded.
REQ-026 Minimum accept-to-push latency 3 cycles (accept, ISSUE, done in first WAIT cycle); next accept possible the cycle after push.
REQ-027 Response FIFO: rsp_valid = not empty; head fields on rsp_* ; pop on rsp_valid & rsp_ready; push and pop same cycle allowed, count unchanged.
REQ-028 Response order SHALL equal command acceptance order.
REQ-029 err_count SHALL saturate at 8'hFF.
REQ-030 Reserved op (11) SHALL be issued like any other; no local short-circuit.

Reset
REQ-031 reset_n low: state IDLE, FIFO empty, counters 0, latched operands 0.
REQ-032 Reset outputs: cmd_ready 0 while reset asserted, unit_start 0, unit_a/b/op 0, rsp_valid 0, rsp_* 0, err_count 0.
REQ-033 Reset mid-operation SHALL abandon the outstanding op with no response produced.

Structure
REQ-034 OP_ADD/OP_SUB/OP_MUL/OP_RESERVED and flag bit index defines SHALL come from fp8_pkg.vh; flag indices added there.
REQ-035 Response FIFO SHALL be sub-module fp8_rsp_fifo (width 17, depth RSP_DEPTH, count output).

Verification
REQ-036 add a=0x38 b=0x38 tag=1, unit model done after 2 cycles -> rsp_result=0x40, tag=1, timeout=0.
REQ-037 mul a=0x40 b=0x40 -> rsp_result=0x48; unit_start high exactly one cycle; operands stable until response.
REQ-038 Unit never responds -> after 16 WAIT cycles rsp_timeout=1, result 0x00, err_count=1; late done afterwards -> err_count=2, no extra response.
REQ-039 rsp_ready=0, issue 5 commands -> 4 responses queued, cmd_ready=0; one pop -> fifth accepted; tags return in order 0..4.
REQ-040 Assert reset_n low during WAIT -> rsp_valid=0, state IDLE, no response; next command completes normally.
REQ-041 unit_done coincident with timeout cycle -> normal response, timeout=0, err_count unchanged.
